// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
// Optional feature macro used by this slice: BCD_DIGIT_CHECK_EN.
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_MAX_DIGIT  = 9;
  localparam int BCD_CORRECTION = 6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction (combinational).
// With BCD_DIGIT_CHECK_EN defined, also flags an operand digit above 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       c,
  output bcd_digit_t s_d,
  output logic       c_out
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic       invalid
`endif
);

  logic [4:0] t;

  // Binary digit sum, then +6 correction when it exceeds 9. Non-BCD inputs
  // go through the same rule unchanged; the 5-bit sum cannot overflow.
  always_comb begin
    t = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c};
    if (t > 5'(BCD_MAX_DIGIT)) begin
      s_d   = t[3:0] + 4'(BCD_CORRECTION);
      c_out = 1'b1;
    end else begin
      s_d   = t[3:0];
      c_out = 1'b0;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  // Either operand digit outside 0..9.
  always_comb begin
    invalid = (a_d > 4'(BCD_MAX_DIGIT)) || (b_d > 4'(BCD_MAX_DIGIT));
  end
`endif

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder sequencer: one digit per clock, LSD first.
// Optional feature macro: BCD_DIGIT_CHECK_EN (adds the err output).
//
//   state | meaning
//   IDLE  | waiting for start
//   ADD   | processing digit[idx], carry held in register
//   DONE  | one-cycle result-valid cycle; start here chains a new op
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t                          state;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0] a_w, b_w, res_w, res_next;
  logic                            carry;
  logic [IW-1:0]                   idx;
  bcd_digit_t                      s_d;
  logic                            c_out;
`ifdef BCD_DIGIT_CHECK_EN
  logic                            invalid;
  logic                            err_flag;
`endif

  bcd_digit_add u_digit (
    .a_d     (a_w[idx]),
    .b_d     (b_w[idx]),
    .c       (carry),
    .s_d     (s_d),
    .c_out   (c_out)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .invalid (invalid)
`endif
  );

  // Working result with the current digit merged in, so the final digit can
  // be loaded into sum on the same edge that completes it.
  always_comb begin
    res_next      = res_w;
    res_next[idx] = s_d;
  end

  // Control FSM with registered outputs and working registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      a_w      <= '0;
      b_w      <= '0;
      res_w    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err      <= 1'b0;
      err_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_w      <= a;
            b_w      <= b;
            carry    <= cin;
            res_w    <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= ADD;
`ifdef BCD_DIGIT_CHECK_EN
            err      <= 1'b0;
            err_flag <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ADD: begin
          res_w <= res_next;
          carry <= c_out;
          idx   <= idx + 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
          if (invalid) err_flag <= 1'b1;
`endif
          if (idx == LAST) begin
            sum   <= res_next;
            cout  <= c_out;
            done  <= 1'b1;
            busy  <= 1'b0;
            idx   <= '0;
            state <= DONE;
`ifdef BCD_DIGIT_CHECK_EN
            err   <= err_flag | invalid;
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl (DIGITS=4).
// Optional feature macro: BCD_DIGIT_CHECK_EN enables the err checks.
module tb_bcd_serial_adder_ctrl;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4*D-1:0] a, b;
  logic          cin;
  logic          busy, done, cout;
  logic [4*D-1:0] sum;
`ifdef BCD_DIGIT_CHECK_EN
  logic          err;
`endif

  int checks   = 0;
  int failures = 0;

  bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [15:0]  a;
    logic [15:0]  b;
    logic         cin;
    logic [15:0]  sum;
    logic         cout;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference: decimal value of operands, plain integer add, back to BCD.
  function automatic void ref_add(input logic [15:0] x, input logic [15:0] y,
                                  input logic c, output logic [15:0] s,
                                  output logic co);
    int vx = 0;
    int vy = 0;
    int tot;
    for (int i = D - 1; i >= 0; i--) begin
      vx = vx * 10 + int'(x[i*4 +: 4]);
      vy = vy * 10 + int'(y[i*4 +: 4]);
    end
    tot = vx + vy + int'(c);
    co  = (tot >= 10000);
    tot = tot % 10000;
    for (int i = 0; i < D; i++) begin
      s[i*4 +: 4] = 4'(tot % 10);
      tot = tot / 10;
    end
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Bounded wait for done, sampled 1 time unit after each edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", done, 1'b1);
  endtask

  // One full operation from IDLE; operands are scrambled after acceptance.
  task automatic do_add(input logic [15:0] x, input logic [15:0] y, input logic c,
                        output logic [15:0] s, output logic co,
                        output int lat, output int bcnt);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", done, 1'b1);
    chk("busy_low_at_done", busy, 1'b0);
    s = sum; co = cout;
    @(posedge clk); #1;
    chk("done_single_pulse", done, 1'b0);
    chk("sum_hold", sum, s);
  endtask

  initial begin
    logic [15:0] s, es;
    logic        co, eco;
    int          lat, bcnt, n;
    bit          seen;

    vecs[0] = '{"basic",       16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0};
    vecs[1] = '{"ripple",      16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{"max",         16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};
    vecs[3] = '{"cin_only",    16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4] = '{"mid_carry",   16'h4321, 16'h0679, 1'b0, 16'h5000, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum",  sum,  16'h0);
    chk("rst_cout", cout, 1'b0);
`ifdef BCD_DIGIT_CHECK_EN
    chk("rst_err", err, 1'b0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat, bcnt);
      chk({vecs[i].name, "_sum"},  s,    vecs[i].sum);
      chk({vecs[i].name, "_cout"}, co,   vecs[i].cout);
      chk({vecs[i].name, "_lat"},  lat,  D + 1);
      chk({vecs[i].name, "_busy"}, bcnt, D);
    end

    // start pulsed mid-ADD is dropped; start held in DONE chains a new op.
    a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1111; b = 16'h1111;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    wait_done(n);
    chk("ignore_sum",  sum,  16'h0010);
    chk("ignore_cout", cout, 1'b0);
    a = 16'h0123; b = 16'h0456; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done", done, 1'b0);
    wait_done(n);
    chk("b2b_lat",  n,   D);
    chk("b2b_sum",  sum, 16'h0579);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("no_queued_op", seen, 1'b0);

    // Reset asserted during the third ADD cycle aborts the operation.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum",  sum,  16'h0);
    chk("abort_cout", cout, 1'b0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
    do_add(16'h0042, 16'h0058, 1'b0, s, co, lat, bcnt);
    chk("after_abort_sum",  s,  16'h0100);
    chk("after_abort_cout", co, 1'b0);

`ifdef BCD_DIGIT_CHECK_EN
    do_add(16'h00A0, 16'h0000, 1'b0, s, co, lat, bcnt);
    chk("err_set",     err, 1'b1);
    chk("err_sum",     s,   16'h0100);
    do_add(16'h0011, 16'h0022, 1'b0, s, co, lat, bcnt);
    chk("err_cleared", err, 1'b0);
    chk("err_ok_sum",  s,   16'h0033);
`endif

    // Random valid-BCD operations against the decimal reference model.
    for (int k = 0; k < 40; k++) begin
      logic [15:0] x, y;
      logic        c;
      x = rand_bcd(); y = rand_bcd(); c = 1'($urandom_range(0, 1));
      ref_add(x, y, c, es, eco);
      do_add(x, y, c, s, co, lat, bcnt);
      chk("rand_sum",  s,   es);
      chk("rand_cout", co,  eco);
      chk("rand_lat",  lat, D + 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
